lfclk_monitor: RTL and testbench

Consumer-side companion to the 32.768 kHz low-frequency clock generator: samples the slow clock inside the 8.388 MHz system domain, synchronises it, and emits one-cycle tick pulses. Measures each slow-clock period in system cycles, declares lock after consecutive in-range periods, and flags range and stall errors. It sits between the slow-clock source and the RTC / always-on timer logic so that they consume clean, single-domain ticks.

---
 rtl/lfclk_monitor.sv | 153 +++++++++++++++
 tb/tb_lfclk_monitor.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/lfclk_monitor.sv
// lfclk_monitor
// Brings the 32.768 kHz slow clock into the clk8388 domain and turns each
// rising edge into a one-cycle tick. Each slow-clock period is measured in
// system cycles. Lock is declared after LOCK_CNT consecutive in-range
// periods. Range and stall errors are flagged and held (sticky).
//
// Ports
//   clk8388    system clock; all logic runs on its rising edge
//   rst        synchronous, active-high reset
//   lfclk_in   asynchronous slow clock
//   en         monitor enable
//   clr_err    pulse that clears err_range / err_stall
//   tick       one-cycle pulse per synchronised lfclk_in rising edge
//   sec_tick   tick on which tick_cnt[14:0] wraps to 0
//   tick_cnt   ticks since enable, modulo 2^32
//   period     last measured period, in clk8388 cycles
//   period_vld one-cycle pulse when period updates
//   lock       frequency locked
//   err_range  sticky: an out-of-range period was measured
//   err_stall  sticky: TIMEOUT cycles passed without an edge
module lfclk_monitor #(
    parameter int EXP_PERIOD = 256,
    parameter int TOL        = 4,
    parameter int LOCK_CNT   = 4,
    parameter int TIMEOUT    = 1024
) (
    input  logic        clk8388,
    input  logic        rst,
    input  logic        lfclk_in,
    input  logic        en,
    input  logic        clr_err,
    output logic        tick,
    output logic        sec_tick,
    output logic [31:0] tick_cnt,
    output logic [15:0] period,
    output logic        period_vld,
    output logic        lock,
    output logic        err_range,
    output logic        err_stall
);

    localparam int              LCW      = $clog2(LOCK_CNT + 1);
    localparam logic [LCW-1:0]  LOCK_MAX = LCW'(LOCK_CNT);
    localparam int              LO_I     = (EXP_PERIOD > TOL) ? EXP_PERIOD - TOL : 0;
    localparam logic [16:0]     RANGE_LO = 17'(LO_I);
    localparam logic [16:0]     RANGE_HI = 17'(EXP_PERIOD + TOL);
    localparam logic [15:0]     CNT_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ARM, MEAS, STALL} state_t;

    state_t           state;
    logic             s1, s2, s3;
    logic             rise;
    logic [15:0]      cnt;
    logic [15:0]      cnt_inc;
    logic [16:0]      meas;
    logic             in_range;
    logic [LCW-1:0]   lock_cnt;
    logic [LCW-1:0]   lock_cnt_inc;
    logic [31:0]      tick_nxt;
    logic             set_range;
    logic             set_stall;

    always_comb begin
        rise         = s2 & ~s3;
        cnt_inc      = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
        // 17-bit so that cnt == 0xFFFF cannot wrap the range compare
        meas         = {1'b0, cnt} + 17'd1;
        in_range     = (meas >= RANGE_LO) && (meas <= RANGE_HI);
        lock_cnt_inc = (lock_cnt == LOCK_MAX) ? lock_cnt : lock_cnt + 1'b1;
        tick_nxt     = tick_cnt + 32'd1;
        set_range    = en && (state == MEAS) && rise && !in_range;
        // A rise in the same cycle as the timeout wins over the stall
        set_stall    = en && ((state == ARM) || (state == MEAS)) && !rise
                       && (cnt == CNT_LAST);
    end

    always_ff @(posedge clk8388) begin
        if (rst) begin
            state      <= IDLE;
            s1         <= 1'b0;
            s2         <= 1'b0;
            s3         <= 1'b0;
            cnt        <= '0;
            lock_cnt   <= '0;
            tick       <= 1'b0;
            sec_tick   <= 1'b0;
            tick_cnt   <= '0;
            period     <= '0;
            period_vld <= 1'b0;
            lock       <= 1'b0;
            err_range  <= 1'b0;
            err_stall  <= 1'b0;
        end else begin
            // Synchroniser runs regardless of en, so a rise already in flight
            // when en goes high is absorbed while in IDLE.
            s1         <= lfclk_in;
            s2         <= s1;
            s3         <= s2;
            tick       <= 1'b0;
            sec_tick   <= 1'b0;
            period_vld <= 1'b0;
            // Set beats a simultaneous clear
            err_range  <= set_range | (err_range & ~clr_err);
            err_stall  <= set_stall | (err_stall & ~clr_err);

            if (!en) begin
                state    <= IDLE;
                cnt      <= '0;
                lock_cnt <= '0;
                lock     <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        state    <= ARM;
                        cnt      <= '0;
                        tick_cnt <= '0;
                    end
                    ARM, STALL, MEAS: begin
                        if (rise) begin
                            tick     <= 1'b1;
                            tick_cnt <= tick_nxt;
                            sec_tick <= (tick_nxt[14:0] == 15'd0);
                            cnt      <= '0;
                            state    <= MEAS;
                            // Only a rise that closes a full period is measured
                            if (state == MEAS) begin
                                period     <= meas[15:0];
                                period_vld <= 1'b1;
                                if (in_range) begin
                                    lock_cnt <= lock_cnt_inc;
                                    lock     <= (lock_cnt_inc == LOCK_MAX);
                                end else begin
                                    lock_cnt <= '0;
                                    lock     <= 1'b0;
                                end
                            end
                        end else begin
                            cnt <= cnt_inc;
                            if (set_stall) begin
                                state    <= STALL;
                                lock     <= 1'b0;
                                lock_cnt <= '0;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lfclk_monitor.sv
// Self-checking bench for lfclk_monitor. Every cycle the DUT outputs are
// compared with a reference model that works on elapsed cycle counts between
// synchronised rises, plus a handful of directed checks at scenario ends.
module tb_lfclk_monitor;

    localparam int EXP   = 256;
    localparam int TOL   = 4;
    localparam int LOCKN = 4;
    localparam int TMO   = 1024;

    logic        clk8388 = 1'b0;
    logic        rst = 1'b1, lfclk_in = 1'b0, en = 1'b0, clr_err = 1'b0;
    logic        tick, sec_tick, period_vld, lock, err_range, err_stall;
    logic [31:0] tick_cnt;
    logic [15:0] period;

    always #60 clk8388 = ~clk8388;

    lfclk_monitor #(.EXP_PERIOD(EXP), .TOL(TOL), .LOCK_CNT(LOCKN), .TIMEOUT(TMO)) dut (
        .clk8388(clk8388), .rst(rst), .lfclk_in(lfclk_in), .en(en), .clr_err(clr_err),
        .tick(tick), .sec_tick(sec_tick), .tick_cnt(tick_cnt), .period(period),
        .period_vld(period_vld), .lock(lock), .err_range(err_range), .err_stall(err_stall)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic summary();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    endtask

    // ---------------- reference model ----------------
    longint      m_cyc = 0, m_start = 0;
    bit          m_on = 0, m_wait = 0;
    int          m_lockn = 0;
    bit [2:0]    hv = '0;             // lfclk_in as sampled at the last three edges
    logic        m_tick = 0, m_sec = 0, m_vld = 0, m_lock = 0, m_er = 0, m_es = 0;
    logic [31:0] m_tcnt = '0;
    logic [15:0] m_period = '0;

    task model_edge(input bit r, input bit e, input bit c, input bit l);
        bit     rise, set_r, set_s;
        longint j;
        m_cyc++;
        rise  = hv[1] & ~hv[2];       // edge sampled two clocks ago, after a low
        set_r = 0;
        set_s = 0;
        if (r) begin
            {m_tick, m_sec, m_vld, m_lock, m_er, m_es} = '0;
            m_tcnt = '0; m_period = '0; m_on = 0; m_lockn = 0; hv = '0;
            return;
        end
        m_tick = 0; m_sec = 0; m_vld = 0;
        if (!e) begin
            m_on = 0; m_lock = 0; m_lockn = 0;
        end else if (!m_on) begin
            m_on = 1; m_wait = 1; m_start = m_cyc; m_tcnt = '0;
        end else begin
            j = m_cyc - m_start;
            if (rise) begin
                m_tick = 1;
                m_tcnt = m_tcnt + 32'd1;
                m_sec  = (m_tcnt[14:0] == 15'd0);
                if (!m_wait) begin
                    m_period = 16'(j);
                    m_vld    = 1;
                    if (j >= EXP - TOL && j <= EXP + TOL) begin
                        if (m_lockn < LOCKN) m_lockn++;
                    end else begin
                        m_lockn = 0;
                        set_r   = 1;
                    end
                    m_lock = (m_lockn == LOCKN);
                end
                m_wait  = 0;
                m_start = m_cyc;
            end else if (j == TMO) begin
                set_s = 1; m_wait = 1; m_lock = 0; m_lockn = 0;
            end
        end
        m_er = set_r | (m_er & ~c);
        m_es = set_s | (m_es & ~c);
        hv   = {hv[1:0], l};
    endtask

    // ---------------- stimulus ----------------
    int          clr_plan = 0;        // 1: clear on next measured rise, 2: clear next cycle
    bit          rnd_clr = 0;
    logic [31:0] sec_first = '0;

    task automatic step(input bit r, input bit e, input bit l, input bit c);
        bit rise_k, cc, chk_same, chk_next;
        rise_k   = hv[1] & ~hv[2];
        cc       = c;
        chk_same = 0;
        chk_next = 0;
        if (clr_plan == 1 && rise_k && !r) begin
            cc = 1; clr_plan = 2; chk_same = 1;
        end else if (clr_plan == 2) begin
            cc = 1; clr_plan = 0; chk_next = 1;
        end
        rst = r; en = e; lfclk_in = l; clr_err = cc;
        model_edge(r, e, cc, l);
        @(posedge clk8388);
        @(negedge clk8388);
        chk("outs", {tick, sec_tick, tick_cnt, period, period_vld, lock, err_range, err_stall},
                    {m_tick, m_sec, m_tcnt, m_period, m_vld, m_lock, m_er, m_es});
        if (chk_same) chk("clr_same_cycle", err_range, 1);
        if (chk_next) chk("clr_next_cycle", err_range, 0);
        if (sec_tick && sec_first == 0) sec_first = tick_cnt;
        if (n_bad > 50) begin
            summary();
            $finish;
        end
    endtask

    task automatic run_period(input int p);
        for (int i = 0; i < p; i++)
            step(0, 1, i < p / 2, rnd_clr && ($urandom_range(0, 15) == 0));
    endtask

    initial begin
        // reset
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
        chk("rst_outs", {tick, sec_tick, tick_cnt, period, period_vld, lock, err_range, err_stall}, 0);

        // nominal period, lock after four measured periods
        for (int i = 0; i < 7; i++) run_period(256);
        chk("lock_256", lock, 1);
        chk("period_256", period, 256);

        // one long period breaks lock, four good ones restore it, 260 is in range
        run_period(261);
        for (int i = 0; i < 5; i++) run_period(256);
        chk("err_range_261", err_range, 1);
        chk("relock", lock, 1);
        run_period(260);
        run_period(256);
        chk("lock_260", lock, 1);
        chk("period_260_seen", period, 260);

        // clear, then clr_err coincident with an out-of-range measurement
        step(0, 1, 1, 1);
        run_period(255);
        chk("err_range_cleared", err_range, 0);
        run_period(250);
        clr_plan = 1;
        run_period(256);
        run_period(256);

        // stall: hold lfclk_in low
        for (int i = 0; i < 1100; i++) step(0, 1, 0, 0);
        chk("err_stall", err_stall, 1);
        chk("lock_stall", lock, 0);
        for (int i = 0; i < 3; i++) run_period(256);
        chk("period_after_stall", period, 256);

        // randomised periods, random clears and short enable drops
        rnd_clr = 1;
        for (int k = 0; k < 20; k++) begin
            run_period($urandom_range(246, 266));
            if ($urandom_range(0, 4) == 0) begin
                int n = $urandom_range(1, 5);
                for (int i = 0; i < n; i++) step(0, 0, $urandom_range(0, 1), 0);
            end
        end
        rnd_clr = 0;

        // reset in mid-period
        for (int i = 0; i < 102; i++) step(0, 1, i < 128, 0);
        step(1, 1, 0, 0);
        chk("rst_mid", {tick, sec_tick, tick_cnt, period, period_vld, lock, err_range, err_stall}, 0);
        for (int i = 0; i < 3; i++) run_period(256);
        chk("period_after_rst", period, 256);

        // fast toggling to reach the 15-bit wrap of tick_cnt
        step(0, 0, 0, 0);
        sec_first = '0;
        for (int i = 0; i < 65540; i++) step(0, 1, (i % 2) == 0, 0);
        chk("sec_tick_cnt", sec_first, 32768);

        summary();
        $finish;
    end

endmodule
